bcd_countdown_timer: RTL

Three-digit BCD countdown timer: loads a 000–999 start value, decrements once per prescaled tick and flags expiry. It is the down-counting counterpart of our free-running BCD up-counter. Its `bcd2`/`bcd1`/`bcd0` outputs drive the same `bcd7seg` instances on HEX2..HEX0, and `running`/`expired` drive LEDG for board-level status. Clocked from the 50 MHz board clock.

---
 rtl/bcd_countdown_timer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bcd_countdown_timer.sv
// Three-digit BCD countdown timer: loads 000-999, decrements once per
// prescaled tick, and flags expiry with a done pulse and an expired level.
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned DIV_W    = 26
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_bcd2,
  input  logic [3:0] load_bcd1,
  input  logic [3:0] load_bcd0,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] bcd2,
  output logic [3:0] bcd1,
  output logic [3:0] bcd0,
  output logic       running,
  output logic       tick,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(TICK_DIV - 1);

  state_e           state_q, state_d;
  logic [3:0]       d2_q, d1_q, d0_q;
  logic [3:0]       d2_d, d1_d, d0_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;

  logic count_zero;
  logic count_one;

  assign count_zero = (d2_q == 4'd0) && (d1_q == 4'd0) && (d0_q == 4'd0);
  assign count_one  = (d2_q == 4'd0) && (d1_q == 4'd0) && (d0_q == 4'd1);

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // State and datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      d2_q      <= '0;
      d1_q      <= '0;
      d0_q      <= '0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      d2_q      <= d2_d;
      d1_q      <= d1_d;
      d0_q      <= d0_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  // Next-state: one event per cycle, load > stop > start > tick
  always_comb begin
    state_d = state_q;
    d2_d    = d2_q;
    d1_d    = d1_q;
    d0_d    = d0_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (load) begin
      state_d = IDLE;
      d2_d    = clamp9(load_bcd2);
      d1_d    = clamp9(load_bcd1);
      d0_d    = clamp9(load_bcd0);
      presc_d = '0;
    end else if (stop && (state_q == RUN)) begin
      state_d = PAUSED;
    end else if (start && (state_q == IDLE)) begin
      if (count_zero) begin
        state_d = EXPIRED;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (start && (state_q == PAUSED)) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        if (count_one) begin
          state_d = EXPIRED;
          done_d  = 1'b1;
          d0_d    = 4'd0;
        end else if (d0_q != 4'd0) begin
          d0_d = d0_q - 4'd1;
        end else begin
          d0_d = 4'd9;
          if (d1_q != 4'd0) begin
            d1_d = d1_q - 4'd1;
          end else begin
            d1_d = 4'd9;
            d2_d = d2_q - 4'd1;
          end
        end
      end else begin
        presc_d = presc_q + DIV_W'(1);
      end
    end
  end

  // Status flags follow the next state so they register alongside it
  always_comb begin
    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
  end

  assign bcd2    = d2_q;
  assign bcd1    = d1_q;
  assign bcd0    = d0_q;
  assign running = running_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule
